tm1638_responder: RTL and testbench

Cycle-accurate TM1638 peripheral model: the chip end of the serial link that `tm1638_board_controller` drives. It oversamples CLK/STB/DIO with `clock` and decodes data, address and display-control commands into a 16-byte display RAM. It answers key-read commands by shifting out a 32-bit key scan. It is instantiated in self-test builds, looping back the controller's serial pins, and its protocol-error flag feeds `sticky_failure`.

---
 rtl/tm1638_responder.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// ---------------------------------------------------------------------------
// tm1638_responder
//
// Chip-side model of a TM1638 serial peripheral. The three serial pins are
// oversampled with `clock`, synchronized, edge-detected and decoded into data,
// address and display-control commands that fill a 16-byte display RAM. Key
// read commands shift out a 32-bit key scan on DIO.
//
// Optional feature: define TM1638_RESPONDER_ERROR_CHECK_EN to build the sticky
// protocol-violation checker. Without it `protocol_error` is tied low.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   sio_clk             serial clock from controller (idle high)
//   sio_stb             strobe, active low, frames one transaction
//   sio_data_in         DIO as driven by the controller
//   sio_data_out        DIO value driven during key read
//   sio_data_out_en     DIO output enable
//   keys[7:0]           key states to report, 1 = pressed
//   hgfedcba[63:0]      digit i segments = RAM[2i]
//   ledr[7:0]           ledr[i] = RAM[2i+1] bit 0
//   display_on          display-control bit 3
//   brightness[2:0]     display-control bits [2:0]
//   protocol_error      sticky protocol-violation flag
// ---------------------------------------------------------------------------
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sio_clk,
    input  logic        sio_stb,
    input  logic        sio_data_in,
    output logic        sio_data_out,
    output logic        sio_data_out_en,
    input  logic [7:0]  keys,
    output logic [63:0] hgfedcba,
    output logic [7:0]  ledr,
    output logic        display_on,
    output logic [2:0]  brightness,
    output logic        protocol_error
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    // ------------------------------------------------------------------
    // Input synchronizers plus one extra flop for edge detection.
    // STB resets to "low" so that a strobe already low at reset release
    // can never look like a fresh falling edge; CLK resets to its idle high.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_stb_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_d;
    logic                   r_stb_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_stb_sync <= '0;
            r_dat_sync <= '0;
            r_clk_d    <= 1'b1;
            r_stb_d    <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], sio_clk};
            r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], sio_stb};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], sio_data_in};
            r_clk_d    <= r_clk_sync[SYNC_STAGES-1];
            r_stb_d    <= r_stb_sync[SYNC_STAGES-1];
        end
    end

    logic w_clk;
    logic w_stb;
    logic w_dat;
    logic w_clk_rise;
    logic w_clk_fall;
    logic w_stb_rise;
    logic w_stb_fall;

    assign w_clk      = r_clk_sync[SYNC_STAGES-1];
    assign w_stb      = r_stb_sync[SYNC_STAGES-1];
    assign w_dat      = r_dat_sync[SYNC_STAGES-1];
    assign w_clk_rise =  w_clk & ~r_clk_d;
    assign w_clk_fall = ~w_clk &  r_clk_d;
    assign w_stb_rise =  w_stb & ~r_stb_d;
    assign w_stb_fall = ~w_stb &  r_stb_d;

    // ------------------------------------------------------------------
    // Datapath and FSM state
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;        // the 8th bit comes straight from w_dat
    logic [3:0]  r_addr;
    logic        r_fixed_mode;
    logic        r_display_on;
    logic [2:0]  r_brightness;
    logic [31:0] r_key_shift;
    logic        r_data_out;
    logic        r_data_out_en;

    // Even addresses hold full segment bytes; odd addresses only ever
    // reach the outputs through bit 0, so only that bit is stored.
    logic [7:0]  r_seg_ram [0:7];
    logic [7:0]  r_led_ram;

    logic        w_bit_active;
    logic        w_byte_done;
    logic [7:0]  w_shift_in;
    logic [31:0] w_key_word;

    assign w_bit_active = w_clk_rise && ((r_state == ST_CMD) || (r_state == ST_WR));
    assign w_byte_done  = w_bit_active && (r_bit_cnt == 3'd7);
    assign w_shift_in   = {w_dat, r_shift};    // LSB-first: new bit enters at the top

    // Key k lands in byte (k mod 4), at bit 0 for k<4 and bit 4 for k>=4.
    always_comb begin
        w_key_word = '0;
        for (int k = 0; k < 8; k++) begin
            w_key_word[8 * (k % 4) + ((k < 4) ? 0 : 4)] = keys[k];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_addr        <= '0;
            r_fixed_mode  <= 1'b0;
            r_display_on  <= 1'b0;
            r_brightness  <= '0;
            r_key_shift   <= '0;
            r_data_out    <= 1'b0;
            r_data_out_en <= 1'b0;
            r_led_ram     <= '0;
            for (int k = 0; k < 8; k++) begin
                r_seg_ram[k] <= '0;
            end
        end else begin
            if (w_bit_active) begin
                r_shift   <= w_shift_in[7:1];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_stb_fall) begin
                        r_state   <= ST_CMD;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                ST_CMD: begin
                    if (w_byte_done) begin
                        case (w_shift_in[7:6])
                            2'b01: begin
                                r_fixed_mode <= w_shift_in[2];
                                if (w_shift_in[1]) begin
                                    // Bit 0 goes out now; the first falling edge
                                    // re-presents it so that the controller's
                                    // first sampling rise sees bit 0.
                                    r_state       <= ST_RD;
                                    r_key_shift   <= w_key_word;
                                    r_data_out    <= w_key_word[0];
                                    r_data_out_en <= 1'b1;
                                end else begin
                                    r_state <= ST_WAIT;
                                end
                            end
                            2'b10: begin
                                r_display_on <= w_shift_in[3];
                                r_brightness <= w_shift_in[2:0];
                                r_state      <= ST_WAIT;
                            end
                            2'b11: begin
                                r_addr  <= w_shift_in[3:0];
                                r_state <= ST_WR;
                            end
                            default: begin
                                r_state <= ST_WAIT;
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    if (w_byte_done) begin
                        if (r_addr[0]) begin
                            r_led_ram[r_addr[3:1]] <= w_shift_in[0];
                        end else begin
                            r_seg_ram[r_addr[3:1]] <= w_shift_in;
                        end
                        if (!r_fixed_mode) begin
                            r_addr <= r_addr + 4'd1;
                        end
                    end
                end
                ST_RD: begin
                    // Zeros shift in behind the key word, so reads past
                    // bit 31 drive 0.
                    if (w_clk_fall) begin
                        r_data_out  <= r_key_shift[0];
                        r_key_shift <= {1'b0, r_key_shift[31:1]};
                    end
                end
                default: begin
                end
            endcase

            // Strobe release wins over everything above, but only after a
            // byte completing in the same cycle has been processed.
            if (w_stb_rise) begin
                r_state       <= ST_IDLE;
                r_data_out_en <= 1'b0;
                r_data_out    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_disp
            assign hgfedcba[8*gi +: 8] = r_seg_ram[gi];
            assign ledr[gi]            = r_led_ram[gi];
        end
    endgenerate

    assign sio_data_out    = r_data_out;
    assign sio_data_out_en = r_data_out_en;
    assign display_on      = r_display_on;
    assign brightness      = r_brightness;

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
`ifdef TM1638_RESPONDER_ERROR_CHECK_EN
    logic       r_protocol_error;
    logic [4:0] r_wr_count;
    logic [5:0] r_rd_rises;
    logic [2:0] w_cnt_next;
    logic       w_err_event;

    assign w_cnt_next = w_bit_active ? (r_bit_cnt + 3'd1) : r_bit_cnt;

    always_comb begin
        w_err_event = 1'b0;
        if ((r_state == ST_CMD) && w_byte_done && (w_shift_in[7:6] == 2'b00)) begin
            w_err_event = 1'b1;
        end
        if (w_stb_rise && ((r_state == ST_CMD) || (r_state == ST_WR)) && (w_cnt_next != 3'd0)) begin
            w_err_event = 1'b1;
        end
        if ((r_state == ST_IDLE) && (w_clk_rise || w_clk_fall)) begin
            w_err_event = 1'b1;
        end
        // Key reads are themselves clocked by rises; only rises beyond the
        // 32 key bits count as a read violation.
        if ((r_state == ST_RD) && w_clk_rise && (r_rd_rises == 6'd32)) begin
            w_err_event = 1'b1;
        end
        if ((r_state == ST_WR) && w_byte_done && (r_wr_count == 5'd16)) begin
            w_err_event = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_protocol_error <= 1'b0;
            r_wr_count       <= '0;
            r_rd_rises       <= '0;
        end else begin
            if (w_err_event) begin
                r_protocol_error <= 1'b1;
            end
            if ((r_state == ST_CMD) && w_byte_done) begin
                r_wr_count <= '0;
                r_rd_rises <= '0;
            end
            if ((r_state == ST_WR) && w_byte_done && (r_wr_count != 5'd16)) begin
                r_wr_count <= r_wr_count + 5'd1;
            end
            if ((r_state == ST_RD) && w_clk_rise && (r_rd_rises != 6'd32)) begin
                r_rd_rises <= r_rd_rises + 6'd1;
            end
        end
    end

    assign protocol_error = r_protocol_error;
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// ---------------------------------------------------------------------------
// tb_tm1638_responder
//
// Directed bench for tm1638_responder. A table of write / display-control
// transactions with hand-computed cumulative display state is applied in a
// loop; key reads, abort, same-cycle byte/STB completion and reset during a
// read are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_tm1638_responder;

    localparam int SYNC_STAGES = 2;
    localparam int PH          = SYNC_STAGES + 4;   // CLK/STB phase length

`ifdef TM1638_RESPONDER_ERROR_CHECK_EN
    localparam logic EXP_ABORT_ERR = 1'b1;
`else
    localparam logic EXP_ABORT_ERR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        sio_clk;
    logic        sio_stb;
    logic        sio_data_in;
    logic        sio_data_out;
    logic        sio_data_out_en;
    logic [7:0]  keys;
    logic [63:0] hgfedcba;
    logic [7:0]  ledr;
    logic        display_on;
    logic [2:0]  brightness;
    logic        protocol_error;

    int n_tests = 0;
    int n_fail  = 0;

    tm1638_responder #(
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sio_clk        (sio_clk),
        .sio_stb        (sio_stb),
        .sio_data_in    (sio_data_in),
        .sio_data_out   (sio_data_out),
        .sio_data_out_en(sio_data_out_en),
        .keys           (keys),
        .hgfedcba       (hgfedcba),
        .ledr           (ledr),
        .display_on     (display_on),
        .brightness     (brightness),
        .protocol_error (protocol_error)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    typedef struct {
        bit          is_disp;
        logic [7:0]  dcmd;
        logic [7:0]  acmd;
        int          nbytes;
        logic [31:0] bytes;
        logic [63:0] exp_seg;
        logic [7:0]  exp_ledr;
        logic        exp_on;
        logic [2:0]  exp_bri;
    } vec_t;

    vec_t vecs [8];

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic stb_begin;
        sio_stb = 1'b0;
        tick(PH);
    endtask

    task automatic stb_end;
        tick(PH);
        sio_stb = 1'b1;
        tick(PH + 2);
    endtask

    task automatic pulse_bit(input logic b);
        sio_clk     = 1'b0;
        sio_data_in = b;
        tick(PH);
        sio_clk     = 1'b1;
        tick(PH);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            pulse_bit(b[i]);
        end
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sio_clk = 1'b0;
            tick(PH);
            b[i]    = sio_data_out;   // value presented when CLK rises
            sio_clk = 1'b1;
            tick(PH);
        end
    endtask

    task automatic one_byte_txn(input logic [7:0] b);
        stb_begin;
        send_byte(b);
        stb_end;
    endtask

    task automatic key_read(input string tag, input int nbytes, input logic [39:0] exp);
        logic [7:0] rb;
        stb_begin;
        send_byte(8'h42);
        for (int j = 0; j < nbytes; j++) begin
            read_byte(rb);
            check($sformatf("%s_byte%0d", tag, j), {56'd0, rb}, {56'd0, exp[8*j +: 8]});
        end
        check($sformatf("%s_oe_during", tag), {63'd0, sio_data_out_en}, 64'd1);
        tick(PH);
        sio_stb = 1'b1;
        tick(SYNC_STAGES + 2);
        check($sformatf("%s_oe_drop", tag), {63'd0, sio_data_out_en}, 64'd0);
        tick(PH);
        $display("[TB] key read %s done", tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_seg"},  hgfedcba, 64'd0);
        check({tag, "_ledr"}, {56'd0, ledr}, 64'd0);
        check({tag, "_on"},   {63'd0, display_on}, 64'd0);
        check({tag, "_bri"},  {61'd0, brightness}, 64'd0);
        check({tag, "_dout"}, {63'd0, sio_data_out}, 64'd0);
        check({tag, "_oe"},   {63'd0, sio_data_out_en}, 64'd0);
        check({tag, "_err"},  {63'd0, protocol_error}, 64'd0);
    endtask

    initial begin
        // seg = {RAM14,RAM12,...,RAM2,RAM0}; ledr bit i = RAM[2i+1][0]
        vecs[0] = '{0, 8'h40, 8'hC0, 4, 32'h0006_013F, 64'h0000_0000_0000_063F, 8'h01, 1'b0, 3'd0};
        vecs[1] = '{0, 8'h44, 8'hC4, 2, 32'h0000_4F5B, 64'h0000_0000_004F_063F, 8'h01, 1'b0, 3'd0};
        vecs[2] = '{1, 8'h8A, 8'h00, 0, 32'h0,         64'h0000_0000_004F_063F, 8'h01, 1'b1, 3'd2};
        vecs[3] = '{1, 8'h80, 8'h00, 0, 32'h0,         64'h0000_0000_004F_063F, 8'h01, 1'b0, 3'd0};
        vecs[4] = '{0, 8'h40, 8'hCF, 3, 32'h0033_2211, 64'h0000_0000_004F_0622, 8'h81, 1'b0, 3'd0};
        vecs[5] = '{1, 8'h8F, 8'h00, 0, 32'h0,         64'h0000_0000_004F_0622, 8'h81, 1'b1, 3'd7};
        vecs[6] = '{0, 8'h44, 8'hCE, 2, 32'h0000_9977, 64'h9900_0000_004F_0622, 8'h81, 1'b1, 3'd7};
        vecs[7] = '{0, 8'h40, 8'hC6, 2, 32'h0000_FE01, 64'h9900_0000_014F_0622, 8'h81, 1'b1, 3'd7};

        reset       = 1'b1;
        sio_clk     = 1'b1;
        sio_stb     = 1'b1;
        sio_data_in = 1'b0;
        keys        = 8'h00;
        tick(5);
        reset = 1'b0;
        tick(PH);
        check_all_zero("reset");

        // ---------------- table-driven write / display vectors ----------
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].is_disp) begin
                one_byte_txn(vecs[v].dcmd);
            end else begin
                one_byte_txn(vecs[v].dcmd);
                stb_begin;
                send_byte(vecs[v].acmd);
                for (int j = 0; j < vecs[v].nbytes; j++) begin
                    send_byte(vecs[v].bytes[8*j +: 8]);
                end
                stb_end;
            end
            check($sformatf("vec%0d_seg", v),  hgfedcba, vecs[v].exp_seg);
            check($sformatf("vec%0d_ledr", v), {56'd0, ledr}, {56'd0, vecs[v].exp_ledr});
            check($sformatf("vec%0d_on", v),   {63'd0, display_on}, {63'd0, vecs[v].exp_on});
            check($sformatf("vec%0d_bri", v),  {61'd0, brightness}, {61'd0, vecs[v].exp_bri});
            $display("[TB] vector %0d cmd %h applied", v, vecs[v].dcmd);
        end
        check("table_err", {63'd0, protocol_error}, 64'd0);

        // ---------------- abort: STB rises after 5 bits of a data byte --
        one_byte_txn(8'h40);
        stb_begin;
        send_byte(8'hC8);
        for (int i = 0; i < 5; i++) begin
            pulse_bit(1'b1);
        end
        stb_end;
        check("abort_seg",  hgfedcba, 64'h9900_0000_014F_0622);
        check("abort_ledr", {56'd0, ledr}, 64'h81);
        check("abort_err",  {63'd0, protocol_error}, {63'd0, EXP_ABORT_ERR});
        $display("[TB] abort transaction done");

        // ---------------- byte completes on the same cycle STB rises ----
        one_byte_txn(8'h40);
        stb_begin;
        send_byte(8'hCA);
        for (int i = 0; i < 7; i++) begin
            pulse_bit(((8'hA5 >> i) & 8'h01) != 0);
        end
        sio_clk     = 1'b0;
        sio_data_in = 1'b1;          // bit 7 of 0xA5
        tick(PH);
        sio_clk = 1'b1;
        sio_stb = 1'b1;
        tick(PH + 2);
        check("samecyc_seg", hgfedcba, 64'h9900_A500_014F_0622);
        check("samecyc_err", {63'd0, protocol_error}, {63'd0, EXP_ABORT_ERR});
        $display("[TB] same-cycle byte/STB transaction done");

        // ---------------- key reads ----------------
        keys = 8'b1000_0001;
        key_read("keyA", 4, 40'h00_1000_0001);
        keys = 8'b0101_1010;
        key_read("keyB", 5, 40'h00_0110_0110);

        // ---------------- reset during bit 12 of a key read -------------
        keys = 8'b1000_0001;
        begin
            logic [7:0] rb;
            stb_begin;
            send_byte(8'h42);
            read_byte(rb);
            check("rstrd_byte0", {56'd0, rb}, 64'h01);
            for (int i = 0; i < 4; i++) begin
                sio_clk = 1'b0;
                tick(PH);
                sio_clk = 1'b1;
                tick(PH);
            end
            sio_clk = 1'b0;
            tick(PH);
            check("rstrd_oe_before", {63'd0, sio_data_out_en}, 64'd1);
            reset = 1'b1;
            tick(1);
            check_all_zero("rstrd");
            sio_clk = 1'b1;
            sio_stb = 1'b1;
            tick(3);
            reset = 1'b0;
            tick(PH);
            $display("[TB] reset during key read done");
        end
        key_read("keyC", 4, 40'h00_1000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20ms;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
